uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the write port of the UART TX fifo between NUM_REQ requesters, with round-robin fairness.
//  - A grant is locked for a whole message, so bytes from different requesters never interleave.
//  - The block sits between the requesters (command engine, debug printer, ...) and fifo wr/w_data/full.
// PARAMETERS
//  DATA_WIDTH   8    bits per word; must match the TX fifo
//  NUM_REQ      4    number of requesters, 2..8
//  ID_W         $clog2(NUM_REQ)  width of the grant index (derived)
//  WDOG_CYCLES  255  idle-lock timeout in cycles; used only with UART_ARB_WDOG_EN
// PORTS
//  clk           in   1                   system clock
//  rst           in   1                   synchronous, active-high reset
//  req_valid     in   NUM_REQ             requester i has a word to send
//  req_last      in   NUM_REQ             the word on requester i is the last of its message
//  req_data      in   NUM_REQ*DATA_WIDTH  flattened data; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  NUM_REQ             requester i's word is accepted this cycle
//  fifo_full     in   1                   TX fifo full flag
//  fifo_wr       out  1                   TX fifo write strobe
//  fifo_w_data   out  DATA_WIDTH          TX fifo write data
//  grant_valid   out  1                   a requester currently holds the lock
//  grant_id      out  ID_W                index of the lock holder
//  wdog_timeout  out  1                   1-cycle pulse when a lock is forcibly released
// BEHAVIOUR
//  - Clock and reset: single clock clk; rst is synchronous and active-high.
//  - Reset: state=IDLE, grant_valid=0, grant_id=0, rr_ptr=NUM_REQ-1, wdog_timeout=0.
//    Consequences: fifo_wr=0, req_ready=0, so requester 0 wins the first arbitration.
//  - A reset mid-message drops the lock immediately. No further fifo_wr is issued.
//  - State machine:
//    - IDLE: if any req_valid, pick the first valid index searching from rr_ptr+1 with wrap-around.
//      Register it into grant_id and go to LOCKED next cycle. No transfer happens in IDLE.
//      This costs a 1-cycle arbitration bubble per message.
//    - LOCKED (g = grant_id): fifo_wr = req_valid[g] & ~fifo_full; req_ready[g] = ~fifo_full.
//      req_ready of every other requester is 0. fifo_w_data = req_data slice g (combinational mux).
//      A write with req_last[g]=1 sets rr_ptr<=g, clears grant_valid and returns to IDLE.
//  - Handshake: a word transfers iff req_valid & req_ready in the same cycle.
//    Requesters hold data/last stable while valid and not ready.
//  - fifo_full=1 stalls the holder: no write and no data loss. The lock persists.
//  - A requester whose valid drops mid-message keeps the lock until its last word arrives.
//  - Requests arriving during LOCKED wait. They are arbitrated only on return to IDLE.
//  - Back-to-back messages from the same requester are allowed only if no other requester is valid.
//  - req_last with req_valid=0 is ignored.
//  - req_* on non-granted indices are ignored.
// CONFIGURATION
//  Macro UART_ARB_WDOG_EN:
//  - Defined: an 8..16-bit idle counter runs while LOCKED and req_valid[g]=0.
//    It clears on any transfer. Stall cycles due to fifo_full do not count.
//    When the count reaches WDOG_CYCLES: wdog_timeout=1 for 1 cycle, go to IDLE, rr_ptr<=g.
//  - Undefined: no counter; wdog_timeout is tied to 0; the lock is released only by req_last.
// STRUCTURE
//  - Package uart_arb_pkg: state enum arb_state_t {IDLE, LOCKED}, max-requester constant.
//  - Sub-module uart_rr_picker (combinational):
//    in: req vector and rr_ptr; out: found and idx.
//    Implements the rotate, find-first and un-rotate.
//  - The top holds the FSM, the grant/pointer registers, the output mux and the optional watchdog.
// TESTING
//  1. rst then req_valid=4'b0001, 3 words 0x41,0x42,0x43 (last on 0x43)
//     -> fifo_wr 3 cycles starting 1 cycle after valid; grant_id=0; IDLE afterwards.
//  2. req_valid=4'b1111 continuously, 1-word messages
//     -> grant_id sequence 0,1,2,3,0; fifo_wr every other cycle.
//  3. Req 1 locked, 4-word message; req 2 asserts mid-message
//     -> no req2 data between req1 words; grant_id=2 only after req1's last.
//  4. fifo_full=1 for 5 cycles mid-message
//     -> fifo_wr=0 and req_ready=0 those cycles; word order intact; no drop or duplicate.
//  5. rst asserted while LOCKED on req 3
//     -> next cycle grant_valid=0, fifo_wr=0, rr_ptr=3; requester 0 wins the next arbitration.
//  6. UART_ARB_WDOG_EN, WDOG_CYCLES=10, holder 2 drops valid without last
//     -> wdog_timeout pulses on idle cycle 10; the lock passes to waiting requester 3.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX write-port arbiter.
// Optional watchdog is enabled by defining UART_ARB_WDOG_EN (see uart_tx_arbiter).
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_REQ = 8;

    // Modulo-n increment used to walk requester indices with wrap-around.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned ofs,
                                             input int unsigned n);
        return (base + ofs) % n;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin find-first: returns the first set req bit searching from ptr+1 with wrap-around.
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    ofs;

    // Rotate so that bit 0 corresponds to requester ptr+1.
    always_comb begin
        rot = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            rot[k] = req[ID_W'(wrap_add(32'(ptr), 32'(k) + 32'd1, NUM_REQ))];
        end
    end

    // Find-first on the rotated vector; descending scan leaves the lowest hit.
    always_comb begin
        found = 1'b0;
        ofs   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                ofs   = ID_W'(k);
            end
        end
    end

    assign idx = ID_W'(wrap_add(32'(ofs), 32'(ptr) + 32'd1, NUM_REQ));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter for the UART TX fifo write port.
// Define UART_ARB_WDOG_EN to release locks held by an idle requester after WDOG_CYCLES.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = $clog2(NUM_REQ),
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id,
    output logic                          wdog_timeout
);

    arb_state_t      state;
    arb_state_t      state_d;
    logic [ID_W-1:0] grant_id_d;
    logic            grant_valid_d;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            locked;
    logic            holder_valid;
    logic            holder_last;
    logic            xfer;
    logic            wdog_fire_c;

    // Configurations outside 2..MAX_REQ requesters or a zero timeout are unsupported.
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || WDOG_CYCLES == 0) begin : g_cfg_unsupported
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A reset cycle already counts as lock-dropped so no stray write slips out.
    assign locked       = (state == LOCKED) && !rst;
    assign holder_valid = req_valid[grant_id];
    assign holder_last  = req_last[grant_id];
    assign xfer         = locked && holder_valid && !fifo_full;

    assign fifo_wr     = xfer;
    assign fifo_w_data = req_data[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        if (locked) begin
            req_ready[grant_id] = !fifo_full;
        end
    end

    // Next-state: arbitrate in IDLE, hold the lock until last word or watchdog.
    always_comb begin
        state_d       = state;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        rr_ptr_d      = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d       = LOCKED;
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                end
            end
            LOCKED: begin
                if ((xfer && holder_last) || wdog_fire_c) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = grant_id;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
        end else begin
            state       <= state_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            rr_ptr      <= rr_ptr_d;
        end
    end

`ifdef UART_ARB_WDOG_EN
    localparam int unsigned WDOG_W = 16;

    logic [WDOG_W-1:0] idle_cnt;
    logic              wdog_q;

    // Fires on the WDOG_CYCLES-th consecutive cycle the holder has nothing valid.
    assign wdog_fire_c = locked && !holder_valid
                         && (idle_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_fire_c;
            if (state != LOCKED || xfer || wdog_fire_c) begin
                idle_cnt <= '0;
            end else if (!holder_valid) begin
                idle_cnt <= idle_cnt + WDOG_W'(1);
            end
        end
    end

    assign wdog_timeout = wdog_q;
`else
    assign wdog_fire_c  = 1'b0;
    assign wdog_timeout = 1'b0;
`endif

endmodule
